transport_uart_tx: RTL

//   Serialises the 8-bit switch code from the Transport stage onto a UART line (8N1, LSB first).

---
 rtl/uart_pkg.sv | 6 +
 rtl/transport_uart_tx_if.sv | 10 +
 rtl/uart_baud_tick.sv | 17 +
 rtl/transport_uart_tx.sv | 72 +++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared state encoding and frame geometry for the transport UART transmitter
package uart_pkg;
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
    localparam int FRAME_BITS = 10;
    localparam int DATA_BITS = 8;
endpackage

// File: rtl/transport_uart_tx_if.sv
// transport_uart_tx_if: byte/request inputs and serial/status outputs of the UART transmitter
interface transport_uart_tx_if;
    logic [7:0] data_in;
    logic send;
    logic tx;
    logic busy;
    logic drop;
    modport master (output data_in, send, input tx, busy, drop);
    modport slave (input data_in, send, output tx, busy, drop);
endinterface

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: free-running bit-period counter with a tick on the last cycle of each bit
module uart_baud_tick #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);
    localparam int W = $clog2(CLKS_PER_BIT);
    localparam logic [W-1:0] LAST = W'(CLKS_PER_BIT - 1);
    logic [W-1:0] cnt;
    always_ff @(posedge clk or negedge rst)
        if (!rst) cnt <= '0;
        else cnt <= (clr || tick) ? '0 : cnt + 1'b1;
    assign tick = cnt == LAST;
endmodule

// File: rtl/transport_uart_tx.sv
// transport_uart_tx: 8N1 LSB-first serialiser for the Transport byte with a 1-entry holding register
module transport_uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434,
    parameter bit SEND_ON_CHANGE = 1'b1
) (
    input logic clk,
    input logic rst,
    transport_uart_tx_if.slave bus
);
    localparam int IW = $clog2(FRAME_BITS);
    localparam logic [IW-1:0] LAST_IDX = IW'(DATA_BITS - 1);
    state_t state;
    logic [7:0] last_q, hold_d, shift;
    logic [IW-1:0] idx;
    logic hold_v, tx_q, drop_q, tick, req, take;
    assign req = bus.send | (SEND_ON_CHANGE & (bus.data_in != last_q));
    // the shifter claims the held byte from IDLE or at the end of a stop bit
    assign take = hold_v & ((state == IDLE) | ((state == STOP) & tick));
    uart_baud_tick #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
        .clk (clk),
        .rst (rst),
        .clr (state == IDLE),
        .tick(tick)
    );
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            state <= IDLE;
            last_q <= '0;
            hold_d <= '0;
            hold_v <= 1'b0;
            shift <= '0;
            idx <= '0;
            tx_q <= 1'b1;
            drop_q <= 1'b0;
        end else begin
            last_q <= bus.data_in;
            drop_q <= req & hold_v & ~take;
            if (req) begin
                hold_d <= bus.data_in;
                hold_v <= 1'b1;
            end else if (take) hold_v <= 1'b0;
            if (take) begin
                state <= START;
                shift <= hold_d;
                tx_q <= 1'b0;
            end else
                case (state)
                    START: if (tick) begin
                        state <= DATA;
                        idx <= '0;
                        tx_q <= shift[0];
                    end
                    DATA: if (tick) begin
                        if (idx == LAST_IDX) begin
                            state <= STOP;
                            tx_q <= 1'b1;
                        end else begin
                            idx <= idx + 1'b1;
                            shift <= shift >> 1;
                            tx_q <= shift[1];
                        end
                    end
                    STOP: if (tick) state <= IDLE;
                    default: tx_q <= 1'b1;
                endcase
        end
    assign bus.tx = tx_q;
    assign bus.drop = drop_q;
    assign bus.busy = (state != IDLE) | hold_v;
endmodule
